// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - walks all input vectors of a combinational block and checks y against TRUTH.
// Optional first-mismatch log enabled by `define TTC_ERROR_LOG_EN.
module truth_table_checker #(
  parameter int                      N_IN       = 3,
  parameter logic [(2**N_IN)-1:0]    TRUTH      = 8'h31,
  parameter int                      SETTLE_CYC = 2,
  parameter int                      CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             y_i,
  output logic [N_IN-1:0]  vec_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef TTC_ERROR_LOG_EN
  output logic             first_err_vld,
  output logic [N_IN-1:0]  first_err_idx,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW       = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int LAST_CNT = (SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0;

  generate
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("truth_table_checker: SETTLE_CYC must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fvld_q, fvld_d;
  logic [N_IN-1:0]  fidx_q, fidx_d;
  logic             mismatch;

  // DRIVE and SETTLE together hold a vector for SETTLE_CYC clocks; vector 0 skips DRIVE
  // because vec_o already sits at 0 while idle.
  state_t           first_wait;
  assign first_wait = (SETTLE_CYC == 1) ? S_SAMPLE : S_SETTLE;
  assign mismatch   = (y_i != TRUTH[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    fvld_d  = fvld_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          fvld_d  = 1'b0;
          fidx_d  = '0;
          cnt_d   = '0;
          state_d = first_wait;
        end
      end
      S_DRIVE: begin
        cnt_d   = '0;
        state_d = first_wait;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(LAST_CNT)) state_d = S_SAMPLE;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        if (mismatch && !(&err_q)) err_d = err_q + CNT_W'(1);
        if (mismatch && !fvld_q) begin
          fvld_d = 1'b1;
          fidx_d = vec_q;
        end
        if (&vec_q) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        vec_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef TTC_ERROR_LOG_EN
  assign first_err_vld = fvld_q;
  assign first_err_idx = fidx_q;
`else
  logic unused_log;
  assign unused_log = fvld_q ^ (^fidx_q);
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker (main instance plus a CNT_W=2 instance).
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;
  logic [7:0] truth_tb = 8'h31;

  logic       y_a, y_b;
  logic [2:0] vec_a, vec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a;
  logic [1:0] err_b;
`ifdef TTC_ERROR_LOG_EN
  logic       fvld_a, fvld_b;
  logic [2:0] fidx_a, fidx_b;
`endif

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(3), .TRUTH(8'h31), .SETTLE_CYC(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .y_i(y_a), .vec_o(vec_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
`ifdef TTC_ERROR_LOG_EN
    .first_err_vld(fvld_a), .first_err_idx(fidx_a),
`endif
    .err_cnt(err_a)
  );

  truth_table_checker #(.N_IN(3), .TRUTH(8'h31), .SETTLE_CYC(2), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .y_i(y_b), .vec_o(vec_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
`ifdef TTC_ERROR_LOG_EN
    .first_err_vld(fvld_b), .first_err_idx(fidx_b),
`endif
    .err_cnt(err_b)
  );

  // Gate model: 0 ideal, 1 stuck-at-0, 2 inverted, 3 wrong only at vector 5
  function automatic logic ymodel(input int m, input logic [2:0] v);
    logic ideal;
    ideal = truth_tb[v];
    case (m)
      1:       return 1'b0;
      2:       return ~ideal;
      3:       return ideal ^ (v == 3'd5);
      default: return ideal;
    endcase
  endfunction

  assign y_a = ymodel(mode, vec_a);
  assign y_b = ymodel(mode, vec_b);

  typedef struct {
    logic [3:0] err;
    logic       pass;
    logic [1:0] sat;
    logic       fvld;
    logic [2:0] fidx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Hand-derived: TRUTH=0x31 has ones at vectors 0,4,5
  int   exp_errs [4] = '{0, 3, 8, 1};
  int   exp_fidx [4] = '{0, 0, 0, 5};

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_err_cnt", int'(err_a), int'(e.err));
        chk("done_pass", int'(pass_a), int'(e.pass));
        chk("done_busy_low", int'(busy_a), 0);
        chk("sat_done_sync", int'(done_b), 1);
        chk("sat_err_cnt", int'(err_b), int'(e.sat));
        chk("sat_pass", int'(pass_b), int'(e.pass));
`ifdef TTC_ERROR_LOG_EN
        chk("first_err_vld", int'(fvld_a), int'(e.fvld));
        chk("first_err_idx", int'(fidx_a), int'(e.fidx));
        chk("sat_first_err_idx", int'(fidx_b), int'(e.fidx));
`endif
      end
    end
  end

  // One run: start held for hold_cyc edges; abort_at>=0 applies reset at that observed cycle.
  task automatic do_run(input int m, input int hold_cyc, input int abort_at);
    int   busy_n = 0, done_n = 0, vec_bad = 0, expv;
    exp_t e;
    mode = m;
    if (abort_at < 0) begin
      e.err  = 4'(exp_errs[m]);
      e.pass = (exp_errs[m] == 0);
      e.sat  = (exp_errs[m] > 3) ? 2'd3 : 2'(exp_errs[m]);
      e.fvld = (exp_errs[m] != 0);
      e.fidx = 3'(exp_fidx[m]);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j == hold_cyc - 1) start = 1'b0;
      if (j == abort_at) begin
        chk("vec_before_abort", int'(vec_a), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_vec", int'(vec_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_pass", int'(pass_a), 0);
        chk("abort_err", int'(err_a), 0);
`ifdef TTC_ERROR_LOG_EN
        chk("abort_fvld", int'(fvld_a), 0);
`endif
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (done_a || busy_a) done_n++;
        end
        chk("abort_no_done", done_n, 0);
        return;
      end
      if (busy_a) busy_n++;
      if (done_a) begin
        done_n++;
        chk("done_cycle", j, 24);
      end
      expv = (j < 2) ? 0 : ((j - 2) / 3 + 1);
      if (expv > 7) expv = 7;
      if (j > 23) expv = 0;
      if (int'(vec_a) != expv) vec_bad++;
    end
    chk("busy_cycles", busy_n, 24);
    chk("done_pulses", done_n, 1);
    chk("vec_steps", vec_bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vec", int'(vec_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_pass", int'(pass_a), 0);
    chk("reset_err", int'(err_a), 0);
    reset = 1'b0;
    @(negedge clk);

    do_run(0, 1, -1);   // golden
    do_run(1, 1, -1);   // stuck-at-0
    do_run(2, 1, -1);   // inverted; CNT_W=2 instance saturates
    do_run(0, 25, -1);  // start held through busy and DONE cycle
    chk("hold_pass_kept", int'(pass_a), 1);
    do_run(3, 1, -1);   // fresh run re-clears err_cnt, single error at 5
    chk("err_held_idle", int'(err_a), 1);
    do_run(1, 1, 9);    // reset while vec_o=3
    do_run(0, 1, -1);   // run after abort starts at vector 0

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
